// File: rtl/pacote_memoria.sv
// Shared definitions for the load/store stage and the 100-word data memory.
package pacote_memoria;

  localparam int unsigned LARGURA = 8;
  localparam int unsigned TAM_MEM = 100;

  // Controller states; the state itself records whether the request was a load, store or error
  typedef enum logic [2:0] {
    OCIOSO,
    ESCRITA,
    LEITURA,
    RESPOSTA,
    ERRO
  } estado_t;

endpackage

// File: rtl/contador_saturado.sv
// Up-counter with enable that sticks at its maximum value instead of wrapping.
module contador_saturado #(
  parameter int unsigned LARGURA_CONT = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_en,
  output logic [LARGURA_CONT-1:0] o_valor
);

  logic [LARGURA_CONT-1:0] r_valor;

  // Count enabled events, holding at all-ones
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_valor <= '0;
    end else if (i_en && (r_valor != '1)) begin
      r_valor <= r_valor + LARGURA_CONT'(1);
    end
  end

  assign o_valor = r_valor;

endmodule

// File: rtl/estagio_acesso_memoria.sv
// Load/store controller in front of the data memory: one request at a time, registered
// memory strobes, range check, load results returned over a valid/ready handshake.
module estagio_acesso_memoria #(
  parameter int unsigned LARGURA   = pacote_memoria::LARGURA,
  parameter int unsigned TAM_MEM   = pacote_memoria::TAM_MEM,
  parameter int unsigned LARG_DEST = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_req_valido,
  input  logic                 i_req_escrita,
  input  logic [LARGURA-1:0]   i_req_endereco,
  input  logic [LARGURA-1:0]   i_req_dado,
  input  logic [LARG_DEST-1:0] i_req_destino,
  output logic                 o_req_pronto,
  output logic [LARGURA-1:0]   o_mem_endereco,
  output logic [LARGURA-1:0]   o_mem_dado_escr,
  output logic                 o_mem_esc,
  output logic                 o_mem_ler,
  input  logic [LARGURA-1:0]   i_mem_dado_lido,
  output logic                 o_wb_valido,
  output logic [LARG_DEST-1:0] o_wb_destino,
  output logic [LARGURA-1:0]   o_wb_dado,
  input  logic                 i_wb_pronto,
  output logic                 o_erro_endereco,
  output logic [7:0]           o_cont_leituras,
  output logic [7:0]           o_cont_escritas,
  output logic [7:0]           o_cont_erros
);

  import pacote_memoria::*;

  localparam logic [LARGURA-1:0] LIMITE = LARGURA'(TAM_MEM);

  estado_t r_estado;
  estado_t w_prox_estado;
  logic    w_aceita;

  logic [LARGURA-1:0]   r_endereco;
  logic [LARGURA-1:0]   r_dado;
  logic [LARG_DEST-1:0] r_destino;
  logic [LARGURA-1:0]   r_wb_dado;
  logic                 r_mem_esc;
  logic                 r_mem_ler;
  logic                 r_wb_valido;
  logic                 r_erro;

  // Next-state decode; only OCIOSO looks at the request inputs
  always_comb begin
    w_prox_estado = r_estado;
    w_aceita      = 1'b0;
    unique case (r_estado)
      OCIOSO: begin
        if (i_req_valido) begin
          w_aceita = 1'b1;
          if (i_req_endereco >= LIMITE) begin
            w_prox_estado = ERRO;
          end else if (i_req_escrita) begin
            w_prox_estado = ESCRITA;
          end else begin
            w_prox_estado = LEITURA;
          end
        end
      end
      ESCRITA:  w_prox_estado = OCIOSO;
      LEITURA:  w_prox_estado = RESPOSTA;
      RESPOSTA: begin
        if (i_wb_pronto) begin
          w_prox_estado = OCIOSO;
        end
      end
      ERRO:     w_prox_estado = OCIOSO;
      default:  w_prox_estado = OCIOSO;
    endcase
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // Strobes are decoded from the next state so they leave flops aligned with the state
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_mem_esc   <= 1'b0;
      r_mem_ler   <= 1'b0;
      r_wb_valido <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      r_mem_esc   <= (w_prox_estado == ESCRITA);
      r_mem_ler   <= (w_prox_estado == LEITURA);
      r_wb_valido <= (w_prox_estado == RESPOSTA);
      r_erro      <= (w_prox_estado == ERRO);
    end
  end

  // Request fields are captured only on acceptance, so they stay put during the access
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_endereco <= '0;
      r_dado     <= '0;
      r_destino  <= '0;
    end else if (w_aceita) begin
      r_endereco <= i_req_endereco;
      r_dado     <= i_req_dado;
      r_destino  <= i_req_destino;
    end
  end

  // Load data is captured at the end of the read cycle and held through the response
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wb_dado <= '0;
    end else if (r_estado == LEITURA) begin
      r_wb_dado <= i_mem_dado_lido;
    end
  end

  contador_saturado #(
    .LARGURA_CONT (8)
  ) u_cont_leituras (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_en    (r_estado == LEITURA),
    .o_valor (o_cont_leituras)
  );

  contador_saturado #(
    .LARGURA_CONT (8)
  ) u_cont_escritas (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_en    (r_estado == ESCRITA),
    .o_valor (o_cont_escritas)
  );

  contador_saturado #(
    .LARGURA_CONT (8)
  ) u_cont_erros (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_en    (r_estado == ERRO),
    .o_valor (o_cont_erros)
  );

  assign o_req_pronto    = (r_estado == OCIOSO);
  assign o_mem_endereco  = r_endereco;
  assign o_mem_dado_escr = r_dado;
  assign o_mem_esc       = r_mem_esc;
  assign o_mem_ler       = r_mem_ler;
  assign o_wb_valido     = r_wb_valido;
  assign o_wb_destino    = r_destino;
  assign o_wb_dado       = r_wb_dado;
  assign o_erro_endereco = r_erro;

endmodule

// File: tb/tb_estagio_acesso_memoria.sv
// Self-checking bench: transaction-level reference model plus directed literal checks.
module tb_estagio_acesso_memoria;

  localparam int T_ST  = 0;
  localparam int T_LD  = 1;
  localparam int T_ERR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valido = 1'b0;
  logic       req_escrita = 1'b0;
  logic [7:0] req_endereco = '0;
  logic [7:0] req_dado = '0;
  logic [2:0] req_destino = '0;
  logic       req_pronto;
  logic [7:0] mem_endereco;
  logic [7:0] mem_dado_escr;
  logic       mem_esc;
  logic       mem_ler;
  logic [7:0] mem_dado_lido;
  logic       wb_valido;
  logic [2:0] wb_destino;
  logic [7:0] wb_dado;
  logic       wb_pronto = 1'b1;
  logic       erro_endereco;
  logic [7:0] cont_leituras;
  logic [7:0] cont_escritas;
  logic [7:0] cont_erros;

  int n_tests = 0;
  int n_fail  = 0;
  int ciclo   = 0;
  int wb_modo = 0;
  bit chk_en  = 1'b0;

  estagio_acesso_memoria dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_req_valido    (req_valido),
    .i_req_escrita   (req_escrita),
    .i_req_endereco  (req_endereco),
    .i_req_dado      (req_dado),
    .i_req_destino   (req_destino),
    .o_req_pronto    (req_pronto),
    .o_mem_endereco  (mem_endereco),
    .o_mem_dado_escr (mem_dado_escr),
    .o_mem_esc       (mem_esc),
    .o_mem_ler       (mem_ler),
    .i_mem_dado_lido (mem_dado_lido),
    .o_wb_valido     (wb_valido),
    .o_wb_destino    (wb_destino),
    .o_wb_dado       (wb_dado),
    .i_wb_pronto     (wb_pronto),
    .o_erro_endereco (erro_endereco),
    .o_cont_leituras (cont_leituras),
    .o_cont_escritas (cont_escritas),
    .o_cont_erros    (cont_erros)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ciclo++;

  // Environment memory: asynchronous read, level write sampled at the clock edge
  logic [7:0] mem_amb [0:99];
  assign mem_dado_lido = (mem_endereco < 8'd100) ? mem_amb[mem_endereco] : 8'h00;
  always @(posedge clk) begin
    if (mem_esc && mem_endereco < 8'd100) mem_amb[mem_endereco] <= mem_dado_escr;
  end

  // Reference model: a request occupies the block for a fixed number of phases
  logic [7:0] ref_mem [0:99];
  int         m_fase = -1;
  int         m_tipo = T_ST;
  int         m_aceites = 0;
  int         m_cl = 0, m_ce = 0, m_cerr = 0;
  logic [7:0] m_end = '0, m_dado = '0, m_dado_wb = '0;
  logic [2:0] m_tag = '0;

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fase = -1; m_end = '0; m_dado = '0; m_tag = '0; m_dado_wb = '0;
      m_cl = 0; m_ce = 0; m_cerr = 0;
    end else begin
      case (m_fase)
        -1: if (req_valido) begin
          m_end = req_endereco; m_dado = req_dado; m_tag = req_destino;
          m_tipo = (req_endereco >= 8'd100) ? T_ERR : (req_escrita ? T_ST : T_LD);
          m_fase = 1;
          m_aceites++;
        end
        1: begin
          if (m_tipo == T_ST) begin
            ref_mem[m_end] = m_dado; m_ce = sat(m_ce); m_fase = -1;
          end else if (m_tipo == T_ERR) begin
            m_cerr = sat(m_cerr); m_fase = -1;
          end else begin
            m_dado_wb = ref_mem[m_end]; m_cl = sat(m_cl); m_fase = 2;
          end
        end
        default: if (wb_pronto) m_fase = -1;
      endcase
    end
  end

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("req_pronto", 32'(req_pronto), 32'(m_fase == -1));
      chk("mem_esc", 32'(mem_esc), 32'(m_fase == 1 && m_tipo == T_ST));
      chk("mem_ler", 32'(mem_ler), 32'(m_fase == 1 && m_tipo == T_LD));
      chk("erro_endereco", 32'(erro_endereco), 32'(m_fase == 1 && m_tipo == T_ERR));
      chk("wb_valido", 32'(wb_valido), 32'(m_fase == 2));
      chk("cont_leituras", 32'(cont_leituras), 32'(m_cl));
      chk("cont_escritas", 32'(cont_escritas), 32'(m_ce));
      chk("cont_erros", 32'(cont_erros), 32'(m_cerr));
      if (m_fase == 1 && m_tipo != T_ERR) chk("mem_endereco", 32'(mem_endereco), 32'(m_end));
      if (m_fase == 1 && m_tipo == T_ST) chk("mem_dado_escr", 32'(mem_dado_escr), 32'(m_dado));
      if (m_fase == 2) begin
        chk("wb_dado", 32'(wb_dado), 32'(m_dado_wb));
        chk("wb_destino", 32'(wb_destino), 32'(m_tag));
      end
    end
  end

  // Write-back ready: 0 = always ready, 1 = random, 2 = driven by the directed test
  initial begin
    forever begin
      @(posedge clk); #1;
      if (wb_modo == 0) wb_pronto = 1'b1;
      else if (wb_modo == 1) wb_pronto = 1'($urandom);
    end
  end

  // Present a request and hold it until accepted; returns just after the accepting edge
  task automatic envia(input logic esc, input logic [7:0] a, input logic [7:0] d,
                       input logic [2:0] t);
    int antes;
    bit ok;
    antes = m_aceites;
    ok = 1'b0;
    req_valido = 1'b1; req_escrita = esc; req_endereco = a; req_dado = d; req_destino = t;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk); #1;
      if (m_aceites != antes) ok = 1'b1;
    end
    req_valido = 1'b0;
    req_escrita = 1'($urandom); req_endereco = 8'($urandom); req_dado = 8'($urandom);
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got no acceptance, required acceptance within 50 cycles");
    end
  endtask

  int c0, c1;

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 100; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem_amb[i] = v;
      ref_mem[i] = v;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_pronto", 32'(req_pronto), 32'd1);
    chk("rst_mem_esc", 32'(mem_esc), 32'd0);
    chk("rst_mem_ler", 32'(mem_ler), 32'd0);
    chk("rst_wb_valido", 32'(wb_valido), 32'd0);
    chk("rst_erro", 32'(erro_endereco), 32'd0);
    chk("rst_counters", {8'd0, cont_leituras, cont_escritas, cont_erros}, 32'd0);
    chk("rst_regs", {8'd0, mem_endereco, mem_dado_escr, wb_dado}, 32'd0);
    chk_en = 1'b1;

    // Store 0x5A at 0x10
    envia(1'b1, 8'h10, 8'h5A, 3'd0);
    @(negedge clk);
    chk("st_mem_esc_c1", 32'(mem_esc), 32'd1);
    chk("st_addr_c1", 32'(mem_endereco), 32'h10);
    chk("st_data_c1", 32'(mem_dado_escr), 32'h5A);
    @(negedge clk);
    chk("st_mem_esc_c2", 32'(mem_esc), 32'd0);
    chk("st_pronto_c2", 32'(req_pronto), 32'd1);
    chk("st_cont", 32'(cont_escritas), 32'd1);
    chk("st_no_wb", 32'(wb_valido), 32'd0);

    // Load 0x10, tag 3
    envia(1'b0, 8'h10, 8'h00, 3'd3);
    @(negedge clk);
    chk("ld_mem_ler_c1", 32'(mem_ler), 32'd1);
    chk("ld_wb_c1", 32'(wb_valido), 32'd0);
    @(negedge clk);
    chk("ld_wb_c2", 32'(wb_valido), 32'd1);
    chk("ld_dado_c2", 32'(wb_dado), 32'h5A);
    chk("ld_tag_c2", 32'(wb_destino), 32'd3);
    @(negedge clk);
    chk("ld_pronto_c3", 32'(req_pronto), 32'd1);
    chk("ld_cont", 32'(cont_leituras), 32'd1);

    // Load with write-back stalled for 5 cycles
    envia(1'b1, 8'h20, 8'h33, 3'd0);
    wb_modo = 2; wb_pronto = 1'b0;
    envia(1'b0, 8'h20, 8'h00, 3'd5);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_wb_valido", 32'(wb_valido), 32'd1);
      chk("hold_wb_dado", 32'(wb_dado), 32'h33);
      chk("hold_wb_tag", 32'(wb_destino), 32'd5);
      chk("hold_pronto", 32'(req_pronto), 32'd0);
    end
    wb_pronto = 1'b1;
    @(negedge clk);
    chk("hold_done_wb", 32'(wb_valido), 32'd0);
    chk("hold_done_pronto", 32'(req_pronto), 32'd1);
    wb_modo = 0;

    // Out-of-range stores
    envia(1'b1, 8'd100, 8'hAA, 3'd0);
    @(negedge clk);
    chk("err100_pulse", 32'(erro_endereco), 32'd1);
    chk("err100_no_esc", 32'(mem_esc), 32'd0);
    @(negedge clk);
    chk("err100_end", 32'(erro_endereco), 32'd0);
    envia(1'b1, 8'd255, 8'hBB, 3'd0);
    @(negedge clk);
    chk("err255_pulse", 32'(erro_endereco), 32'd1);
    chk("err255_no_esc", 32'(mem_esc), 32'd0);
    @(negedge clk);
    chk("err_cont", 32'(cont_erros), 32'd2);

    // Reset in the middle of a store
    envia(1'b1, 8'h05, 8'h77, 3'd0);
    #3;
    chk("rstmid_esc_before", 32'(mem_esc), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_esc_dropped", 32'(mem_esc), 32'd0);
    chk("rstmid_strobes", {29'd0, mem_ler, wb_valido, erro_endereco}, 32'd0);
    chk("rstmid_counters", {8'd0, cont_leituras, cont_escritas, cont_erros}, 32'd0);
    chk("rstmid_regs", {8'd0, mem_endereco, mem_dado_escr, wb_dado}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    envia(1'b0, 8'h10, 8'h00, 3'd1);
    @(negedge clk); @(negedge clk);
    chk("rstmid_ld_dado", 32'(wb_dado), 32'h5A);
    @(negedge clk);
    chk("rstmid_ld_cont", 32'(cont_leituras), 32'd1);

    // 300 back-to-back stores
    for (int i = 0; i < 300; i++) begin
      envia(1'b1, 8'(i % 100), 8'(i), 3'd0);
      if (i == 0) c0 = ciclo;
      if (i == 299) c1 = ciclo;
    end
    @(negedge clk); @(negedge clk);
    chk("b2b_spacing", 32'(c1 - c0), 32'd598);
    chk("b2b_saturated", 32'(cont_escritas), 32'd255);

    // Random traffic
    wb_modo = 1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      envia(1'($urandom), 8'($urandom_range(0, 119)), 8'($urandom), 3'($urandom));
    end
    wb_modo = 0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/estagio_acesso_memoria.md
# estagio_acesso_memoria

Load/store controller that sits directly upstream of the 100-word data memory in the 8-bit processor. It accepts one load or store request at a time from the execute stage through a valid/ready handshake and drives the memory's address, write-data, write-enable and read-enable lines from registers. Load results are returned to the write-back stage through a second valid/ready handshake. It range-checks addresses and keeps saturating access counters for debug.

## Interface
- LARGURA, 8, data and address width
- TAM_MEM, 100, number of valid memory words; legal addresses are 0..TAM_MEM-1
- LARG_DEST, 3, width of the destination-register tag
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_valido  in  1  execute stage presents a request
- req_escrita  in  1  1 = store, 0 = load
- req_endereco  in  LARGURA  memory address
- req_dado  in  LARGURA  store data (ignored for loads)
- req_destino  in  LARG_DEST  register tag for the load result
- req_pronto  out  1  block can accept a request this cycle
- mem_endereco  out  LARGURA  to memory address port
- mem_dado_escr  out  LARGURA  to memory write-data port
- mem_esc  out  1  to memory write enable
- mem_ler  out  1  to memory read enable
- mem_dado_lido  in  LARGURA  from memory read-data port
- wb_valido  out  1  load result available
- wb_destino  out  LARG_DEST  tag of the load result
- wb_dado  out  LARGURA  load data
- wb_pronto  in  1  write-back stage accepts the result
- erro_endereco  out  1  one-cycle pulse: rejected out-of-range request
- cont_leituras, cont_escritas, cont_erros  out  8 each  saturating counters

## Operation
- FSM states: OCIOSO, ESCRITA, LEITURA, RESPOSTA, ERRO.
- OCIOSO: req_pronto=1. A request is accepted when req_valido and req_pronto are both 1. On acceptance, the address, data, tag and type are latched.
  - If the address is TAM_MEM or greater, go to ERRO.
  - Else, if req_escrita=1, go to ESCRITA.
  - Else, go to LEITURA.
- ESCRITA: mem_esc=1 for exactly one cycle, with mem_endereco and mem_dado_escr held from registers. Increment cont_escritas. Return to OCIOSO. A store produces no write-back.
- LEITURA: mem_ler=1 and mem_endereco is driven. At the cycle's end, capture mem_dado_lido into wb_dado. Increment cont_leituras. Go to RESPOSTA.
- RESPOSTA: wb_valido=1 with wb_dado and wb_destino held stable. When wb_pronto=1, return to OCIOSO. Otherwise, stay in RESPOSTA indefinitely.
- ERRO: pulse erro_endereco for one cycle. mem_esc and mem_ler stay 0, so memory is never touched. Increment cont_erros. Return to OCIOSO.
- req_pronto=0 in every state other than OCIOSO. Requests presented then are not accepted and must be held by the execute stage.
- Counters saturate at 255 and never wrap.
- mem_esc, mem_ler, mem_endereco and mem_dado_escr are direct flop outputs, free of glitches. The memory write is level-sensitive, so the address and data must not change while mem_esc=1.

## Timing
- Reset (reset=0) takes effect immediately, without waiting for a clock edge:
  - state returns to OCIOSO;
  - mem_esc, mem_ler, wb_valido, erro_endereco = 0;
  - req_pronto = 1 once reset is released;
  - all data, address and tag registers = 0;
  - all counters = 0.
- Reset during ESCRITA drops mem_esc asynchronously. A store interrupted this way may be partial; that is acceptable.
- Reset during RESPOSTA discards the pending result.
- Load: accepted at edge 0; mem_ler high in cycle 1; wb_valido high from cycle 2. Minimum 3 cycles from acceptance to the next req_pronto.
- Store: accepted at edge 0; mem_esc high in cycle 1 only; req_pronto high again in cycle 2.
- Error: erro_endereco high in cycle 1; req_pronto high in cycle 2.
- Outputs are never combinationally dependent on req_* or wb_pronto, except req_pronto, which is 1 exactly when the state is OCIOSO.

## Structure
- Shared package pacote_memoria holds:
  - the FSM state enum;
  - constants TAM_MEM=100 and LARGURA=8, also used by the data memory.
- One sub-module: contador_saturado (8-bit, enable input, async active-low reset), instantiated three times.

## Test plan
- Reset, then store 0x5A at address 0x10. Expect: mem_esc high for exactly 1 cycle with mem_endereco=0x10 and mem_dado_escr=0x5A; cont_escritas=1; wb_valido stays 0.
- Load from 0x10 with tag 3, wb_pronto=1, model memory returning 0x5A. Expect: wb_valido in cycle 2 with wb_dado=0x5A and wb_destino=3; cont_leituras=1.
- Load with wb_pronto held at 0 for 5 cycles. Expect: wb_valido and wb_dado stay stable for all 5 cycles; req_pronto=0 throughout; completion on the cycle wb_pronto rises.
- Store to address 100 (0x64), then 255. Expect: erro_endereco pulses once per request; mem_esc never rises; cont_erros=2.
- Assert reset=0 mid-cycle during ESCRITA. Expect: mem_esc drops before the next clock edge; all outputs at reset values; a following load completes normally.
- Issue 300 stores back-to-back. Expect: cont_escritas saturates at 255; req_pronto rises every 2nd cycle.
